// File: rtl/sap_1_pkg.sv
// Shared definitions for the SAP-1 output stage: UART FSM states, frame
// width and default sizing of the divider and capture FIFO.
package sap_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_BITS        = 8;
    localparam int DEF_CLK_DIV      = 16;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Level counters need one bit more than the pointer index to represent "full".
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; rdata is presented combinationally
// from the read pointer so a pop consumes the word visible in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // A write into a full FIFO is only legal when a read frees the slot on the same edge.
    assign w_wr_en = push & (~full | pop);
    assign w_rd_en = pop & ~empty;

    assign level = r_wr_ptr - r_rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sap_out_uart.sv
// SAP-1 output stage: captures changes of the core's output bus into a FIFO
// and serialises each byte as an 8N1 UART frame on tx.
module sap_out_uart
    import sap_1_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int LVL_W     = lvl_width(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bus_in,
    input  logic             capture_en,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int DIV_W = $clog2(CLK_DIV);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [7:0]           r_last_val;
    logic                 r_overflow;
    logic [DIV_W-1:0]     r_div;
    logic [DIV_W-1:0]     w_div_nxt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           r_shreg;
    logic [7:0]           w_shreg_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 w_cap;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           w_rdata;
    logic [LVL_W-1:0]     w_level;
    logic                 w_div_end;
    logic                 w_last_bit;

    // A change is still recorded in last_val when the FIFO rejects it.
    assign w_cap      = capture_en & (bus_in != r_last_val);
    assign w_push     = w_cap & (~w_full | w_pop);
    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit == 3'(UART_BITS - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (bus_in),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Change detector history and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_val <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_cap) begin
                r_last_val <= bus_in;
            end
            if (w_cap & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FSM state and transmit datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= {DIV_W{1'b0}};
            r_bit   <= 3'd0;
            r_shreg <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_START;
                else          w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (w_div_end) w_state_nxt = ST_DATA;
                else           w_state_nxt = ST_START;
            end
            ST_DATA: begin
                if (w_div_end && w_last_bit) w_state_nxt = ST_STOP;
                else                         w_state_nxt = ST_DATA;
            end
            ST_STOP: begin
                if (w_div_end) w_state_nxt = w_empty ? ST_IDLE : ST_START;
                else           w_state_nxt = ST_STOP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath next values; STOP reloads directly so frames run back to back.
    always_comb begin
        w_pop       = 1'b0;
        w_div_nxt   = r_div + DIV_W'(1);
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_tx_nxt    = r_tx;
        case (r_state)
            ST_IDLE: begin
                w_div_nxt = {DIV_W{1'b0}};
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_rdata;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = 1'b0;
                end else begin
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_START: begin
                if (w_div_end) begin
                    w_div_nxt = {DIV_W{1'b0}};
                    w_tx_nxt  = r_shreg[0];
                end else begin
                    w_tx_nxt  = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_div_end) begin
                    w_div_nxt = {DIV_W{1'b0}};
                    if (w_last_bit) begin
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shreg_nxt = {1'b0, r_shreg[7:1]};
                        w_tx_nxt    = r_shreg[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_div_end) begin
                    w_div_nxt = {DIV_W{1'b0}};
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shreg_nxt = w_rdata;
                        w_bit_nxt   = 3'd0;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            default: begin
                w_div_nxt = {DIV_W{1'b0}};
                w_tx_nxt  = 1'b1;
            end
        endcase
    end

    assign tx         = r_tx;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;
    assign busy       = (r_state != ST_IDLE) | (w_level != {LVL_W{1'b0}});

endmodule

// File: doc/sap_out_uart.md
# sap_out_uart

Downstream output stage for the SAP-1 core. Consumes the registered 8-bit `bus_out`, captures each new value into a small FIFO, and serialises it as 8N1 UART frames on one output pin. This makes program results observable off-chip without sampling eight parallel pins. It sits between `sap_1.bus_out` and the top-level output pins.

## Interface

Reset is asynchronous and active-low. The port is named `rst` per codebase naming, but it is active-low.

Parameters:
- `CLK_DIV`, default 16: clock cycles per UART bit. Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: capture FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: the same clock driving `sap_1`.
- `rst` in 1: asynchronous active-low reset.
- `bus_in` in 8: connects to `sap_1.bus_out`.
- `capture_en` in 1: when high, change detection on `bus_in` is armed.
- `tx` out 1: UART serial output. Idles high.
- `busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `overflow` out 1: sticky flag. Set when a capture is dropped because the FIFO is full.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of bytes currently queued.

## Operation

Capture:
- Register `last_val` holds the previously captured byte. It resets to 0x00.
- A push occurs on an edge when `capture_en`=1 and `bus_in != last_val`. The same edge sets `last_val <= bus_in`.
- `last_val` updates whenever the push condition holds, even if the FIFO is full and the byte is dropped.
- FIFO full and no pop on the same edge: the byte is dropped and `overflow <= 1`. `overflow` clears only on reset.
- FIFO full with a pop on the same edge: the push is accepted and the level is unchanged.
- FIFO read/write pointers wrap modulo `FIFO_DEPTH`. An extra MSB distinguishes full from empty.

Transmitter FSM, states IDLE, START, DATA, STOP:
- IDLE: `tx`=1. If the FIFO is non-empty: pop, load the shift register, clear the bit counter and divider, set `tx`=0, go to START.
- START: hold for `CLK_DIV` cycles. Then `tx` = shreg[0], go to DATA.
- DATA: each bit is held `CLK_DIV` cycles, LSB first, shifting right. After bit 7 completes: `tx`=1, go to STOP.
- STOP: hold `tx`=1 for `CLK_DIV` cycles. At the end, if the FIFO is non-empty, pop immediately and go to START with `tx`=0 (no idle gap). Otherwise go to IDLE.
- The divider counter is `$clog2(CLK_DIV)` bits and counts 0..CLK_DIV-1. The bit counter is 3 bits.
- `tx` is driven from a register, so there are no combinational glitches.
- `busy` = (state != IDLE) | (fifo_level != 0).

Reset values:
- `tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0.
- FSM=IDLE, `last_val`=0x00.

Reset asserted mid-frame aborts the frame immediately. `tx` returns to 1 asynchronously and the FIFO contents are discarded.

## Timing

- Latency: a byte pushed on edge k, with the FIFO empty and FSM in IDLE, pops on edge k+1. `tx` is low from edge k+1.
- Frame length is exactly 10·`CLK_DIV` cycles, measured from the `tx` falling edge to the next possible falling edge.
- The STOP→START transition happens on the edge that ends the stop bit.
- Sustained throughput is one byte per 10·`CLK_DIV` cycles. Faster bus changes accumulate in the FIFO, then drop.
- A push and a pop on the same edge: `fifo_level` is unchanged. The popped byte is the oldest entry.
- `bus_in` is already registered upstream, so no synchronisers are needed (same clock domain).

## Structure

- Shared package `sap_1_pkg` holds:
  - the `uart_state_t` enum (IDLE, START, DATA, STOP);
  - the `UART_BITS`=8 constant;
  - the default `CLK_DIV` and `FIFO_DEPTH` constants.
- One sub-module, `sync_fifo`:
  - parameterised width and depth;
  - ports: push, pop, wdata, rdata, full, empty, level;
  - asynchronous active-low reset;
  - `rdata` is combinational from the read pointer.
- The top level contains the change detector, the overflow flag, and the TX FSM, divider, and shift register.

## Test plan

- Reset, then drive `bus_in`=0x00 with `capture_en`=1 for 100 cycles → `tx` stays 1, `busy`=0, no push (value equals reset `last_val`).
- `CLK_DIV`=4, single change to 0xA5 → `tx` falls on the next edge, then carries bits 1,0,1,0,0,1,0,1 (LSB first) at 4 cycles each, then stop=1. Frame is 40 cycles; `busy` drops after the stop bit.
- Changes 0x01, 0x02, 0x03 on consecutive cycles → three back-to-back frames with no idle between them. `fifo_level` peaks at 2 (the first byte is popped on the cycle after its capture) and bytes arrive in order.
- `FIFO_DEPTH`=4, six distinct values on consecutive cycles while the first frame is sending → five bytes are transmitted (one in flight plus four queued), the sixth is dropped, `overflow`=1 and stays 1 until reset.
- `capture_en`=0 while `bus_in` toggles → no frames. Then raise `capture_en` with `bus_in`=0x3C → exactly one frame of 0x3C.
- Assert `rst` low mid-DATA → `tx`=1 immediately. After release: `fifo_level`=0, `overflow`=0, FSM in IDLE, and no residual frame.
